gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor_pkg.sv | 29 ++
 rtl/gshare_predictor_if.sv | 45 ++++
 rtl/gshare_predictor_counter.sv | 23 ++
 rtl/gshare_predictor.sv | 118 +++++++++++
 tb/tb_gshare_predictor.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/gshare_predictor_pkg.sv
//------------------------------------------------------------------------------
// Module : predictor_pkg
// Brief  : Shared constants and saturating-counter helpers for gshare_predictor.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package predictor_pkg;

  localparam int PC_LSB = 1;

  // Helpers operate on a 4-bit container since counters are at most 4 bits wide.
  function automatic logic [3:0] ctr_reset(input int width);
    return 4'((1 << (width - 1)) - 1);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input int width);
    logic [3:0] top;
    top = 4'((1 << width) - 1);
    return (value >= top) ? top : value + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] value);
    return (value == 4'd0) ? 4'd0 : value - 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gshare_predictor_if.sv
//------------------------------------------------------------------------------
// Module : gshare_predictor_if
// Brief  : Query/update bundle between ifetch/ROB and gshare_predictor.
//          Stats ports exist only when PREDICTOR_STATS_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gshare_predictor_if #(
  parameter int HISTORY_WIDTH = 5
);
  logic                     query;
  logic [31:0]              query_pc;
  logic                     predict_valid;
  logic                     predict_result;
  logic [HISTORY_WIDTH-1:0] predict_ghr;
  logic                     update;
  logic [31:0]              update_pc;
  logic [HISTORY_WIDTH-1:0] update_ghr;
  logic                     update_result;
  logic                     update_mispredict;
`ifdef PREDICTOR_STATS_EN
  logic [31:0]              stat_updates;
  logic [31:0]              stat_mispredicts;
`endif

  modport master (
    output query, query_pc, update, update_pc, update_ghr, update_result, update_mispredict,
`ifdef PREDICTOR_STATS_EN
    input  stat_updates, stat_mispredicts,
`endif
    input  predict_valid, predict_result, predict_ghr
  );

  modport slave (
    input  query, query_pc, update, update_pc, update_ghr, update_result, update_mispredict,
`ifdef PREDICTOR_STATS_EN
    output stat_updates, stat_mispredicts,
`endif
    output predict_valid, predict_result, predict_ghr
  );

endinterface

`default_nettype wire

// File: rtl/gshare_predictor_counter.sv
//------------------------------------------------------------------------------
// Module : pht_counter_next
// Brief  : Combinational next value of a saturating PHT counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pht_counter_next
  import predictor_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] old_value,
  input  logic             taken,
  output logic [WIDTH-1:0] new_value
);

  assign new_value = taken ? WIDTH'(sat_inc(4'(old_value), WIDTH))
                           : WIDTH'(sat_dec(4'(old_value)));

endmodule

`default_nettype wire

// File: rtl/gshare_predictor.sv
//------------------------------------------------------------------------------
// Module : gshare_predictor
// Brief  : Gshare branch predictor: PHT indexed by PC xor GHR, speculative
//          history with commit-time repair. Optional stats: PREDICTOR_STATS_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gshare_predictor
  import predictor_pkg::*;
#(
  parameter int INDEX_WIDTH   = 5,
  parameter int COUNTER_WIDTH = 2,
  parameter int HISTORY_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  gshare_predictor_if.slave pred
);

  localparam int c_ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] c_CTR_RST = COUNTER_WIDTH'(ctr_reset(COUNTER_WIDTH));

  logic [COUNTER_WIDTH-1:0] r_pht [c_ENTRIES];
  logic [HISTORY_WIDTH-1:0] r_ghr;
  logic [HISTORY_WIDTH-1:0] r_predict_ghr;
  logic                     r_valid;
  logic                     r_result;

  logic [INDEX_WIDTH-1:0]   w_qidx;
  logic [INDEX_WIDTH-1:0]   w_uidx;
  logic [COUNTER_WIDTH-1:0] w_q_ctr;
  logic [COUNTER_WIDTH-1:0] w_u_ctr;
  logic [COUNTER_WIDTH-1:0] w_u_ctr_next;
  logic                     w_q_taken;
  logic [HISTORY_WIDTH-1:0] w_ghr_next;
  logic                     w_unused;

  assign w_qidx    = pred.query_pc[INDEX_WIDTH:PC_LSB] ^ INDEX_WIDTH'(r_ghr);
  assign w_uidx    = pred.update_pc[INDEX_WIDTH:PC_LSB] ^ INDEX_WIDTH'(pred.update_ghr);
  assign w_q_ctr   = r_pht[w_qidx];
  assign w_u_ctr   = r_pht[w_uidx];
  assign w_q_taken = w_q_ctr[COUNTER_WIDTH-1];

  assign w_unused = ^{pred.query_pc[31:INDEX_WIDTH+1], pred.query_pc[0],
                      pred.update_pc[31:INDEX_WIDTH+1], pred.update_pc[0],
                      w_q_ctr[COUNTER_WIDTH-2:0]};

  pht_counter_next #(
    .WIDTH     (COUNTER_WIDTH)
  ) u_ctr_next (
    .old_value (w_u_ctr),
    .taken     (pred.update_result),
    .new_value (w_u_ctr_next)
  );

  // Truncating {history, bit} keeps the newest HISTORY_WIDTH bits; also
  // covers HISTORY_WIDTH == 1. Commit repair wins over the speculative shift.
  always_comb begin
    w_ghr_next = r_ghr;
    if (pred.query) begin
      w_ghr_next = HISTORY_WIDTH'({r_ghr, w_q_taken});
    end
    if (pred.update && pred.update_mispredict) begin
      w_ghr_next = HISTORY_WIDTH'({pred.update_ghr, pred.update_result});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_pht[i] <= c_CTR_RST;
      end
      r_ghr         <= '0;
      r_valid       <= 1'b0;
      r_result      <= 1'b0;
      r_predict_ghr <= '0;
    end else if (rdy) begin
      r_valid <= pred.query;
      if (pred.query) begin
        r_result      <= w_q_taken;
        r_predict_ghr <= r_ghr;
      end
      if (pred.update) begin
        r_pht[w_uidx] <= w_u_ctr_next;
      end
      r_ghr <= w_ghr_next;
    end
  end

  assign pred.predict_valid  = r_valid;
  assign pred.predict_result = r_result;
  assign pred.predict_ghr    = r_predict_ghr;

`ifdef PREDICTOR_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (rdy && pred.update) begin
      r_stat_updates <= r_stat_updates + 32'd1;
      if (pred.update_mispredict) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign pred.stat_updates     = r_stat_updates;
  assign pred.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gshare_predictor.sv
//------------------------------------------------------------------------------
// Module : tb_gshare_predictor
// Brief  : Directed plus randomized checks of gshare_predictor against an
//          integer reference model. Stats checked when PREDICTOR_STATS_EN set.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gshare_predictor;

  localparam int IW   = 5;
  localparam int CW   = 2;
  localparam int HW   = 5;
  localparam int NENT = 1 << IW;
  localparam int HMOD = 1 << HW;
  localparam int CMAX = (1 << CW) - 1;
  localparam int CWNT = (1 << (CW - 1)) - 1;
  localparam int CHALF = 1 << (CW - 1);

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  gshare_predictor_if #(.HISTORY_WIDTH(HW)) pred ();

  gshare_predictor #(
    .INDEX_WIDTH   (IW),
    .COUNTER_WIDTH (CW),
    .HISTORY_WIDTH (HW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .pred (pred)
  );

  always #5 clk = ~clk;

  int          m_pht [NENT];
  int          m_ghr;
  int          m_valid;
  int          m_res;
  int          m_pghr;
  int unsigned m_su;
  int unsigned m_sm;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic, applied at the clock edge.
  task automatic model(input bit r, input bit rd, input bit q, input logic [31:0] qpc,
                       input bit u, input logic [31:0] upc, input int ughr,
                       input bit ures, input bit umis);
    int g;
    int qi;
    int ui;
    int p;
    if (r) begin
      for (int i = 0; i < NENT; i++) m_pht[i] = CWNT;
      m_ghr = 0; m_valid = 0; m_res = 0; m_pghr = 0; m_su = 0; m_sm = 0;
    end else if (rd) begin
      g = m_ghr;
      if (q) begin
        qi = int'((qpc >> 1) & (NENT - 1)) ^ m_ghr;
        p  = (m_pht[qi] >= CHALF) ? 1 : 0;
        m_res = p; m_pghr = m_ghr; m_valid = 1;
        g = (m_ghr * 2 + p) % HMOD;
      end else begin
        m_valid = 0;
      end
      if (u) begin
        ui = int'((upc >> 1) & (NENT - 1)) ^ (ughr % HMOD);
        if (ures) m_pht[ui] = (m_pht[ui] < CMAX) ? m_pht[ui] + 1 : CMAX;
        else      m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
        m_su++;
        if (umis) begin
          m_sm++;
          g = ((ughr % HMOD) * 2 + (ures ? 1 : 0)) % HMOD;
        end
      end
      m_ghr = g;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit rd, input bit q,
                      input logic [31:0] qpc, input bit u, input logic [31:0] upc,
                      input int ughr, input bit ures, input bit umis);
    rst = r; rdy = rd;
    pred.query = q; pred.query_pc = qpc;
    pred.update = u; pred.update_pc = upc; pred.update_ghr = HW'(ughr);
    pred.update_result = ures; pred.update_mispredict = umis;
    @(posedge clk);
    model(r, rd, q, qpc, u, upc, ughr, ures, umis);
    #1;
    check({tag, ".valid"},  32'(pred.predict_valid),  32'(m_valid));
    check({tag, ".result"}, 32'(pred.predict_result), 32'(m_res));
    check({tag, ".ghr"},    32'(pred.predict_ghr),    32'(m_pghr));
`ifdef PREDICTOR_STATS_EN
    check({tag, ".stat_upd"}, pred.stat_updates,     m_su);
    check({tag, ".stat_mis"}, pred.stat_mispredicts, m_sm);
`endif
  endtask

  initial begin
    // Test 1: reset defaults then a query of an untouched entry
    step("rst0", 1, 1, 1, 32'h104, 1, 32'h104, 3, 1, 1);
    step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t1_query", 0, 1, 1, 32'h100, 0, 0, 0, 0, 0);
    check("t1_res_const", 32'(pred.predict_result), 32'd0);
    check("t1_ghr_const", 32'(pred.predict_ghr), 32'd0);

    // Test 2: saturate up, query, saturate down (last update re-zeroes ghr)
    for (int i = 0; i < 3; i++) step("t2_inc", 0, 1, 0, 0, 1, 32'h104, 0, 1, 0);
    step("t2_q_taken", 0, 1, 1, 32'h104, 0, 0, 0, 0, 0);
    check("t2_taken_const", 32'(pred.predict_result), 32'd1);
    for (int i = 0; i < 4; i++) step("t2_dec", 0, 1, 0, 0, 1, 32'h104, 0, 0, (i == 3));
    step("t2_q_nt", 0, 1, 1, 32'h104, 0, 0, 0, 0, 0);
    check("t2_nt_const", 32'(pred.predict_result), 32'd0);

    // Test 3: train index 2^1 = 3, force ghr = 1 by repair, then query
    for (int i = 0; i < 3; i++) step("t3_train", 0, 1, 0, 0, 1, 32'h104, 1, 1, 0);
    step("t3_repair", 0, 1, 0, 0, 1, 32'h104, 0, 1, 1);
    step("t3_query", 0, 1, 1, 32'h104, 0, 0, 0, 0, 0);
    check("t3_taken_const", 32'(pred.predict_result), 32'd1);
    check("t3_ghr_const", 32'(pred.predict_ghr), 32'd1);

    // Test 4: repair beats speculative shift; query reports pre-repair ghr
    step("t4_both", 0, 1, 1, 32'h110, 1, 32'h300, 5'b10110, 1, 1);
    check("t4_res_const", 32'(pred.predict_result), 32'd0);
    step("t4_probe", 0, 1, 1, 32'h000, 0, 0, 0, 0, 0);
    check("t4_ghr_const", 32'(pred.predict_ghr), 32'b01101);

    // Test 5: same-entry collision reads old counter; stall freezes everything
    step("t5_collide", 0, 1, 1, 32'h148, 1, 32'h148, m_ghr, 1, 0);
    step("t5_collide2", 0, 1, 1, 32'h148, 1, 32'h148, m_ghr, 1, 0);
    for (int i = 0; i < 3; i++) step("t5_stall", 0, 0, 1, 32'h14c, 1, 32'h14c, 2, 1, 1);
    step("t5_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t5_after", 0, 1, 1, 32'h148, 0, 0, 0, 0, 0);

`ifdef PREDICTOR_STATS_EN
    // Test 6: statistics counters and reset mid-sequence
    step("t6_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t6_upd", 0, 1, 0, 0, 1, 32'h40 + 32'(4 * i), i, i[0], (i < 2));
    step("t6_noupd_mis", 0, 1, 0, 0, 0, 0, 0, 0, 1);
    check("t6_upd_const", pred.stat_updates, 32'd5);
    check("t6_mis_const", pred.stat_mispredicts, 32'd2);
    step("t6_rst_mid", 1, 1, 0, 0, 1, 32'h40, 0, 1, 1);
    check("t6_upd_zero", pred.stat_updates, 32'd0);
    check("t6_mis_zero", pred.stat_mispredicts, 32'd0);
`endif

    // Randomized traffic over a small PC range to provoke aliasing
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)),
           32'($urandom_range(0, 127)) << 1,
           1'($urandom_range(0, 1)),
           32'($urandom_range(0, 127)) << 1,
           int'($urandom_range(0, HMOD - 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
